vga_pattern_gen: RTL and testbench

VGA_PATTERN_GEN -- requirements
Module: vga_pattern_gen

---
 rtl/vga_pattern_gen.sv | 169 ++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// VGA timing generator with selectable test patterns (bars, checker, gradient, black).
// Define VGA_BORDER_EN to force a full-white one-pixel frame around the active area.
module vga_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLOR_W  = 4,
  parameter int CLK_DIV  = 2,
  parameter int SYNC_POL = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         mode,
  output logic [COLOR_W-1:0] disp_R,
  output logic [COLOR_W-1:0] disp_G,
  output logic [COLOR_W-1:0] disp_B,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [10:0]        x,
  output logic [9:0]         y,
  output logic               frame_start
);

  localparam int   H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int   V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int   DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int   BAR_W    = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
  localparam logic SYNC_ACT = (SYNC_POL != 0);

  logic [DIV_W-1:0]   r_div;
  logic [10:0]        r_h;
  logic [9:0]         r_v;
  logic [1:0]         r_mode;

  logic               w_pe;
  logic               w_origin;
  logic [1:0]         w_mode;
  logic               w_de;
  logic               w_hs_act;
  logic               w_vs_act;
  logic [10:0]        w_bar_idx;
  logic [2:0]         w_bar;
  logic [2:0]         w_bar_rgb;
  logic [11:0]        w_xy;
  logic [COLOR_W-1:0] w_r;
  logic [COLOR_W-1:0] w_g;
  logic [COLOR_W-1:0] w_b;

  assign w_pe     = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_origin = (r_h == '0) && (r_v == '0);
  // The frame's first pixel already uses the mode being captured on that same enable.
  assign w_mode   = w_origin ? mode : r_mode;
  assign w_de     = (r_h < 11'(H_ACTIVE)) && (r_v < 10'(V_ACTIVE));
  assign w_hs_act = (r_h >= 11'(H_ACTIVE + H_FP)) && (r_h <= 11'(H_ACTIVE + H_FP + H_SYNC - 1));
  assign w_vs_act = (r_v >= 10'(V_ACTIVE + V_FP)) && (r_v <= 10'(V_ACTIVE + V_FP + V_SYNC - 1));
  assign w_bar_idx = r_h / 11'(BAR_W);
  assign w_bar     = (w_bar_idx > 11'd7) ? 3'd7 : w_bar_idx[2:0];
  assign w_xy      = {1'b0, r_h} + {2'b00, r_v};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_div  <= '0;
      r_h    <= '0;
      r_v    <= '0;
      r_mode <= '0;
    end else begin
      r_div <= w_pe ? '0 : r_div + DIV_W'(1);
      if (w_pe) begin
        if (w_origin) r_mode <= mode;
        if (r_h == 11'(H_TOTAL - 1)) begin
          r_h <= '0;
          r_v <= (r_v == 10'(V_TOTAL - 1)) ? '0 : r_v + 10'd1;
        end else begin
          r_h <= r_h + 11'd1;
        end
      end
    end
  end

  // {R,G,B} on/off per bar: white, yellow, cyan, green, magenta, red, blue, black.
  always_comb begin
    w_bar_rgb = 3'b000;
    case (w_bar)
      3'd0: w_bar_rgb = 3'b111;
      3'd1: w_bar_rgb = 3'b110;
      3'd2: w_bar_rgb = 3'b011;
      3'd3: w_bar_rgb = 3'b010;
      3'd4: w_bar_rgb = 3'b101;
      3'd5: w_bar_rgb = 3'b100;
      3'd6: w_bar_rgb = 3'b001;
      default: w_bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    w_r = '0;
    w_g = '0;
    w_b = '0;
    case (w_mode)
      2'b00: begin
        w_r = {COLOR_W{w_bar_rgb[2]}};
        w_g = {COLOR_W{w_bar_rgb[1]}};
        w_b = {COLOR_W{w_bar_rgb[0]}};
      end
      2'b01: begin
        if (r_h[5] ^ r_v[5]) begin
          w_r = '1;
          w_g = '1;
          w_b = '1;
        end
      end
      2'b10: begin
        w_r = COLOR_W'(r_h >> 2);
        w_g = COLOR_W'(r_v >> 2);
        w_b = COLOR_W'(w_xy >> 3);
      end
      default: ;
    endcase
`ifdef VGA_BORDER_EN
    if ((r_h == '0) || (r_h == 11'(H_ACTIVE - 1)) ||
        (r_v == '0) || (r_v == 10'(V_ACTIVE - 1))) begin
      w_r = '1;
      w_g = '1;
      w_b = '1;
    end
`else
`endif
    if (!w_de) begin
      w_r = '0;
      w_g = '0;
      w_b = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      disp_R      <= '0;
      disp_G      <= '0;
      disp_B      <= '0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      // Cleared every clock so the pulse lasts one clock even when CLK_DIV > 1.
      frame_start <= 1'b0;
      if (w_pe) begin
        disp_R      <= w_r;
        disp_G      <= w_g;
        disp_B      <= w_b;
        hsync       <= w_hs_act ? SYNC_ACT : ~SYNC_ACT;
        vsync       <= w_vs_act ? SYNC_ACT : ~SYNC_ACT;
        de          <= w_de;
        x           <= w_de ? r_h : '0;
        y           <= w_de ? r_v : '0;
        frame_start <= w_origin;
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen on a reduced timing set; honours VGA_BORDER_EN.
module tb_vga_pattern_gen;

  localparam int   HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int   VA = 40, VF = 2, VS = 2, VB = 3;
  localparam int   HT = HA + HF + HS + HB;
  localparam int   VT = VA + VF + VS + VB;
  localparam int   CW = 4;
  localparam int   DIV = 2;
  localparam logic POL = 1'b0;
  localparam int   FS_BIT = 3 * CW + 24;
  localparam int   BOUND = 20000;
  localparam logic [2:0] BARS [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                      3'b101, 3'b100, 3'b001, 3'b000};

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    mode  = 2'b00;
  logic [CW-1:0] disp_R, disp_G, disp_B;
  logic          hsync, vsync, de, frame_start;
  logic [10:0]   x;
  logic [9:0]    y;

  int n_checks = 0;
  int n_errors = 0;

  vga_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLOR_W(CW), .CLK_DIV(DIV), .SYNC_POL(0)
  ) dut (
    .clock(clock), .reset(reset), .mode(mode),
    .disp_R(disp_R), .disp_G(disp_G), .disp_B(disp_B),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
    .frame_start(frame_start)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] pack(logic fs, logic d, logic hs, logic vs,
                                       int px, int py, int r, int g, int b);
    logic [FS_BIT:0] v;
    v = {fs, d, hs, vs, 11'(px), 10'(py), CW'(r), CW'(g), CW'(b)};
    return 64'(v);
  endfunction

  function automatic logic [63:0] model_pix(int h, int v, logic [1:0] md);
    int r, g, b, bar, px, py, cmax;
    logic d, hs, vs;
    cmax = (1 << CW) - 1;
    d  = (h < HA) && (v < VA);
    px = d ? h : 0;
    py = d ? v : 0;
    hs = (h >= HA + HF && h < HA + HF + HS) ? POL : !POL;
    vs = (v >= VA + VF && v < VA + VF + VS) ? POL : !POL;
    r = 0; g = 0; b = 0;
    case (md)
      2'd0: begin
        bar = px / (HA / 8);
        if (bar > 7) bar = 7;
        r = BARS[bar][2] ? cmax : 0;
        g = BARS[bar][1] ? cmax : 0;
        b = BARS[bar][0] ? cmax : 0;
      end
      2'd1: if ((((px >> 5) ^ (py >> 5)) & 1) != 0) begin r = cmax; g = cmax; b = cmax; end
      2'd2: begin
        r = (px >> 2) % (1 << CW);
        g = (py >> 2) % (1 << CW);
        b = ((px + py) >> 3) % (1 << CW);
      end
      default: ;
    endcase
`ifdef VGA_BORDER_EN
    if (d && (px == 0 || px == HA - 1 || py == 0 || py == VA - 1)) begin
      r = cmax; g = cmax; b = cmax;
    end
`else
`endif
    if (!d) begin r = 0; g = 0; b = 0; end
    return pack((h == 0 && v == 0), d, hs, vs, px, py, r, g, b);
  endfunction

  function automatic logic [63:0] rst_vec();
    return pack(1'b0, 1'b0, !POL, !POL, 0, 0, 0, 0, 0);
  endfunction

  function automatic logic [63:0] dut_vec();
    return pack(frame_start, de, hsync, vsync, int'(x), int'(y),
                int'(disp_R), int'(disp_G), int'(disp_B));
  endfunction

  // Inputs as seen by the DUT at the most recent rising edge.
  logic [1:0] s_mode = 2'b00;
  logic       s_rst  = 1'b1;
  initial forever begin
    @(posedge clock);
    s_mode = mode;
    s_rst  = reset;
  end

  // Reference model and scoreboard, evaluated mid-cycle.
  logic [63:0] exp_q[$];
  int   m_div = 0, m_h = 0, m_v = 0, m_frames = 0;
  logic [1:0] m_mode = 2'b00;
  initial begin
    logic [63:0] e, last;
    logic popped;
    int de_cnt;
    logic full;
    last = rst_vec();
    de_cnt = 0;
    full = 1'b0;
    forever begin
      @(negedge clock);
      if (reset || s_rst) begin
        m_div = 0; m_h = 0; m_v = 0; m_mode = 2'b00;
        exp_q.delete();
        last = rst_vec();
        de_cnt = 0;
        full = 1'b0;
        check_eq("reset_state", dut_vec(), rst_vec());
        continue;
      end
      if (m_div == DIV - 1) begin
        m_div = 0;
        if (m_h == 0 && m_v == 0) m_mode = s_mode;
        exp_q.push_back(model_pix(m_h, m_v, m_mode));
        if (m_h == HT - 1) begin
          m_h = 0;
          if (m_v == VT - 1) begin m_v = 0; m_frames++; end
          else m_v++;
        end else m_h++;
      end else begin
        m_div++;
      end
      popped = (exp_q.size() > 0);
      if (popped) e = exp_q.pop_front();
      else begin e = last; e[FS_BIT] = 1'b0; end
      last = e;
      check_eq(popped ? "pixel" : "pixel_hold", dut_vec(), e);
      if (popped) begin
        if (frame_start) begin
          if (full) check_eq("de_per_frame", 64'(de_cnt), 64'(HA * VA));
          full = 1'b1;
          de_cnt = 0;
        end
        if (de) de_cnt++;
      end
    end
  end

  task automatic wait_line(input int frame, input int line);
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clock);
      if (m_frames == frame && m_v == line) return;
    end
    check_eq("wait_timeout", 64'd1, 64'd0);
  endtask

  task automatic release_and_check();
    @(posedge clock);
    #2 reset = 1'b0;
    @(posedge clock);
    #1 check_eq("fs_edge1", 64'(frame_start), 64'd0);
    @(posedge clock);
    #1 check_eq("fs_origin", 64'({frame_start, de, x, y}), 64'({1'b1, 1'b1, 11'd0, 10'd0}));
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 check_eq("reset_hold", dut_vec(), rst_vec());
    release_and_check();
    wait_line(0, 10);
    @(posedge clock); #2 mode = 2'b01;
    wait_line(1, 5);
    @(posedge clock); #2 mode = 2'b10;
    wait_line(2, 5);
    @(posedge clock); #2 mode = 2'b11;
    wait_line(3, 30);
    @(posedge clock); #2 reset = 1'b1;
    #1 check_eq("reset_async", dut_vec(), rst_vec());
    mode = 2'b00;
    repeat (3) @(posedge clock);
    release_and_check();
    wait_line(3, 12);
    repeat (4) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete (errors=%0d)", n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
